// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits.
// Latency: txOut drops to the start bit one clock after the validIn/readyOut handshake.
// Backpressure: readyOut is high only while idle; validIn while busy is ignored.
// Optional parity bit compiled in with macro UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 234
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic [DATA_BITS-1:0] dataIn,
  input  logic                 validIn,
  output logic                 readyOut,
  input  logic [DIV_WIDTH-1:0] baudDivIn,
`ifdef UART_TX_PARITY_EN
  input  logic                 parityEnIn,
  input  logic                 parityOddIn,
`endif
  output logic                 txOut,
  output logic                 busyOut,
  output logic                 doneOut
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DIV_WIDTH-1:0] presc_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [CNT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 done_q;
  logic                 xfer;
  logic                 wrap;
  logic [DIV_WIDTH-1:0] div_clamped;
`ifdef UART_TX_PARITY_EN
  logic                 par_en_q;
  logic                 par_bit_q;
`endif

  assign xfer        = validIn && readyOut;
  // prescaler has reached the last clock of the current bit
  assign wrap        = (presc_q == div_q - DIV_WIDTH'(1));
  // divisors below 2 would make a bit shorter than the prescaler can express
  assign div_clamped = (baudDivIn < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baudDivIn;
  assign doneOut     = done_q;

  // state register
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next-state: each non-idle state lasts a whole number of bit periods
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (validIn) state_d = S_START;
      S_START: if (wrap) state_d = S_DATA;
      S_DATA: begin
        if (wrap && bit_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (wrap) state_d = S_STOP;
`endif
      S_STOP:  if (wrap && bit_q == LAST_STOP) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from state; illegal encodings look idle-high and not busy
  always_comb begin
    txOut    = 1'b1;
    busyOut  = 1'b0;
    readyOut = 1'b0;
    case (state_q)
      S_IDLE:   readyOut = 1'b1;
      S_START:  begin txOut = 1'b0;       busyOut = 1'b1; end
      S_DATA:   begin txOut = shreg_q[0]; busyOut = 1'b1; end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin txOut = par_bit_q;  busyOut = 1'b1; end
`endif
      S_STOP:   begin txOut = 1'b1;       busyOut = 1'b1; end
      default:  begin txOut = 1'b1;       busyOut = 1'b0; end
    endcase
  end

  // datapath: prescaler, bit counter, shift register, latched frame settings
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      presc_q   <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      div_q     <= DIV_WIDTH'(DEFAULT_DIV);
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == S_STOP) && (state_d == S_IDLE);

      if (state_q == S_IDLE || wrap) presc_q <= '0;
      else                           presc_q <= presc_q + DIV_WIDTH'(1);

      // bit counter restarts on every state change so it never wraps mid-frame
      if (state_d != state_q) bit_q <= '0;
      else if (wrap)          bit_q <= bit_q + CNT_W'(1);

      if (xfer) begin
        shreg_q   <= dataIn;
        div_q     <= div_clamped;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= parityEnIn;
        par_bit_q <= (^dataIn) ^ parityOddIn;
`endif
      end else if (state_q == S_DATA && wrap) begin
        shreg_q <= shreg_q >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame (8N1 default, parity frames when UART_TX_PARITY_EN is defined).
// Expected frames are hand-packed as {stop, [parity], data, start}, bit 0 sent first.
module tb_uart_tx_frame;

  logic        clkIn;
  logic        rstNIn;
  logic [7:0]  dataIn;
  logic        validIn;
  logic        readyOut;
  logic [15:0] baudDivIn;
  logic        parityEnIn;
  logic        parityOddIn;
  logic        txOut;
  logic        busyOut;
  logic        doneOut;

  int n_vec;
  int n_err;

  uart_tx_frame dut (
    .clkIn      (clkIn),
    .rstNIn     (rstNIn),
    .dataIn     (dataIn),
    .validIn    (validIn),
    .readyOut   (readyOut),
    .baudDivIn  (baudDivIn),
`ifdef UART_TX_PARITY_EN
    .parityEnIn (parityEnIn),
    .parityOddIn(parityOddIn),
`endif
    .txOut      (txOut),
    .busyOut    (busyOut),
    .doneOut    (doneOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive a word and let it be taken on the next rising edge; returns 1ns after that edge
  task automatic start_xfer(input string tag, input logic [7:0] d, input logic [15:0] div);
    validIn   = 1'b1;
    dataIn    = d;
    baudDivIn = div;
    check({tag, "_rdy_at_hs"}, 32'(readyOut), 32'd1);
    @(posedge clkIn);
    #1;
    validIn = 1'b0;
  endtask

  // called just after the handshake edge; samples every cycle of an nb-bit frame of D clocks per bit
  task automatic watch_frame(input string tag, input int d, input int nb, input logic [11:0] expf);
    int txe;
    int rdye;
    int busye;
    int donee;
    logic [11:0] got;
    txe = 0; rdye = 0; busye = 0; donee = 0; got = '0;
    for (int k = 0; k < nb * d; k++) begin
      @(negedge clkIn);
      if (txOut !== expf[k / d]) txe++;
      if (k % d == d / 2) got[k / d] = txOut;
      if (readyOut !== 1'b0) rdye++;
      if (busyOut !== 1'b1) busye++;
      if (doneOut !== 1'b0) donee++;
    end
    @(negedge clkIn);
    check({tag, "_frame"},     32'(got), 32'(expf));
    check({tag, "_bit_hold"},  32'(txe), 32'd0);
    check({tag, "_rdy_low"},   32'(rdye), 32'd0);
    check({tag, "_busy_high"}, 32'(busye), 32'd0);
    check({tag, "_no_early_done"}, 32'(donee), 32'd0);
    check({tag, "_done"},      32'(doneOut), 32'd1);
    check({tag, "_end_busy"},  32'(busyOut), 32'd0);
    check({tag, "_end_rdy"},   32'(readyOut), 32'd1);
    check({tag, "_end_tx"},    32'(txOut), 32'd1);
  endtask

  initial begin
    int bad;
    n_vec = 0; n_err = 0;
    rstNIn = 1'b0; validIn = 1'b0; dataIn = '0; baudDivIn = '0;
    parityEnIn = 1'b0; parityOddIn = 1'b0;
    #1;
    check("rst_tx",   32'(txOut), 32'd1);
    check("rst_rdy",  32'(readyOut), 32'd1);
    check("rst_busy", 32'(busyOut), 32'd0);
    check("rst_done", 32'(doneOut), 32'd0);
    @(negedge clkIn);
    @(negedge clkIn);
    rstNIn = 1'b1;
    @(negedge clkIn);

    // 1: 0xA5 at D=4, 40-clock frame
    start_xfer("t1", 8'hA5, 16'd4);
    watch_frame("t1", 4, 10, 12'h34A);

    // 2: validIn held high, back-to-back frames with a single idle clock
    @(negedge clkIn);
    validIn = 1'b1; dataIn = 8'h3C; baudDivIn = 16'd2;
    @(posedge clkIn);
    #1;
    dataIn = 8'hC3;
    watch_frame("t2a", 2, 10, 12'h278);
    @(posedge clkIn);
    #1;
    validIn = 1'b0;
    watch_frame("t2b", 2, 10, 12'h386);

    // 3: inputs change mid-frame; taken only at the next handshake
    @(negedge clkIn);
    start_xfer("t3", 8'h5A, 16'd3);
    validIn = 1'b1; dataIn = 8'hFF; baudDivIn = 16'd10;
    watch_frame("t3a", 3, 10, 12'h2B4);
    @(posedge clkIn);
    #1;
    validIn = 1'b0;
    watch_frame("t3b", 10, 10, 12'h3FE);

    // 4: asynchronous reset in clock 13 of a frame
    @(negedge clkIn);
    start_xfer("t4", 8'h00, 16'd4);
    for (int k = 0; k < 13; k++) @(negedge clkIn);
    check("t4_tx_before_rst", 32'(txOut), 32'd0);
    #2;
    rstNIn = 1'b0;
    #1;
    check("t4_rst_tx",   32'(txOut), 32'd1);
    check("t4_rst_rdy",  32'(readyOut), 32'd1);
    check("t4_rst_busy", 32'(busyOut), 32'd0);
    @(negedge clkIn);
    @(negedge clkIn);
    rstNIn = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clkIn);
      if (doneOut !== 1'b0 || txOut !== 1'b1 || readyOut !== 1'b1) bad++;
    end
    check("t4_quiet_after_rst", 32'(bad), 32'd0);
    start_xfer("t4n", 8'h81, 16'd4);
    watch_frame("t4n", 4, 10, 12'h302);

    // 5: divisors 0 and 1 clamp to 2 clocks per bit
    @(negedge clkIn);
    start_xfer("t5a", 8'h0F, 16'd0);
    watch_frame("t5a", 2, 10, 12'h21E);
    @(negedge clkIn);
    start_xfer("t5b", 8'hF0, 16'd1);
    watch_frame("t5b", 2, 10, 12'h3E0);

`ifdef UART_TX_PARITY_EN
    // 6: parity frames, 0xA5 has four ones
    @(negedge clkIn);
    parityEnIn = 1'b1; parityOddIn = 1'b0;
    start_xfer("t6e", 8'hA5, 16'd4);
    watch_frame("t6e", 4, 11, 12'h54A);
    @(negedge clkIn);
    parityOddIn = 1'b1;
    start_xfer("t6o", 8'hA5, 16'd4);
    watch_frame("t6o", 4, 11, 12'h74A);
    @(negedge clkIn);
    parityEnIn = 1'b0;
    start_xfer("t6n", 8'hA5, 16'd4);
    watch_frame("t6n", 4, 10, 12'h34A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
